// File: rtl/tt_um_jimktrains_vslc_scan_seq.sv
// Scan-cycle sequencer: parses the program header, forwards in-range bytes as
// instructions (1-cycle latency) and restarts the reader per free-run/trigger/periodic mode.
module tt_um_jimktrains_vslc_scan_seq #(
  parameter int ADDR_W = 10,
  parameter int IN_W   = 8,
  parameter int CNT_W  = 16,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              trig_in,
  input  logic              tick,
  input  logic [PER_W-1:0]  period,
  input  logic              clr_flags,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic [ADDR_W-1:0] byte_addr,
  input  logic              restart_ack,
  input  logic [IN_W-1:0]   in_pins,
  output logic              restart_req,
  output logic [ADDR_W-1:0] restart_addr,
  output logic              instr_valid,
  output logic [7:0]        instr_byte,
  output logic [IN_W-1:0]   in_cur,
  output logic [IN_W-1:0]   in_prev,
  output logic              scan_pulse,
  output logic [CNT_W-1:0]  scan_count,
  output logic              overrun,
  output logic              cfg_err
);

  typedef enum logic [2:0] {S_HDR, S_RUN, S_WAIT, S_RESTART, S_HALT} state_t;

  state_t            state_q;
  logic [7:0]        start_hi_q, end_hi_q;
  logic [ADDR_W-1:0] start_q, end_q;
  logic [2:0]        trig_sync_q;
  logic              trig_pend_q;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic              restart_req_q, instr_valid_q, scan_pulse_q, overrun_q, cfg_err_q;
  logic [7:0]        instr_byte_q;
  logic [IN_W-1:0]   in_cur_q, in_prev_q;
  logic [CNT_W-1:0]  scan_count_q;

  logic              trig_rise, busy, pend_set, ovr_set, in_range, hdr_bad, scan_start;
  logic              per_elapsed, per_reach, run_go, wait_go;
  logic [PER_W-1:0]  per_max;
  logic [ADDR_W-1:0] end_d;

  always_comb begin
    trig_rise   = trig_sync_q[1] & ~trig_sync_q[2];
    per_max     = (period == '0) ? PER_W'(1) : period;
    per_elapsed = per_cnt_q >= per_max;
    // "Reaching" is the single tick that crosses the threshold; a saturated
    // counter left over from a period-triggered restart must not re-flag overrun.
    per_reach   = tick && !per_elapsed && ((per_cnt_q + PER_W'(1)) == per_max);
    busy        = (state_q == S_RUN) || (state_q == S_RESTART);
    pend_set    = busy && (mode == 2'd1) && trig_rise;
    ovr_set     = pend_set || (busy && (mode == 2'd2) && per_reach);
    in_range    = (byte_addr >= start_q) && (byte_addr <= end_q);
    end_d       = ADDR_W'({end_hi_q, byte_data});
    hdr_bad     = (end_d == '0) || (end_d < start_q) || (start_q < ADDR_W'(4));
    scan_start  = ((state_q == S_HDR) && byte_valid && (byte_addr == ADDR_W'(3)) && !hdr_bad) ||
                  ((state_q == S_RESTART) && restart_ack);
    run_go      = (mode == 2'd1) ? (trig_pend_q | trig_rise) :
                  (mode == 2'd2) ? (per_elapsed | per_reach) : 1'b1;
    wait_go     = (mode == 2'd1) ? trig_rise :
                  (mode == 2'd2) ? per_elapsed : 1'b1;
    per_cnt_d   = per_cnt_q;
    if (scan_start)
      per_cnt_d = '0;
    else if (tick && (per_cnt_q != '1))
      per_cnt_d = per_cnt_q + PER_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HDR;
      start_hi_q    <= '0;
      end_hi_q      <= '0;
      start_q       <= '0;
      end_q         <= '0;
      trig_sync_q   <= '0;
      trig_pend_q   <= 1'b0;
      per_cnt_q     <= '0;
      restart_req_q <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_byte_q  <= '0;
      scan_pulse_q  <= 1'b0;
      scan_count_q  <= '0;
      in_cur_q      <= '0;
      in_prev_q     <= '0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      trig_sync_q   <= {trig_sync_q[1:0], trig_in};
      per_cnt_q     <= per_cnt_d;
      overrun_q     <= ovr_set | (overrun_q & ~clr_flags);
      scan_pulse_q  <= scan_start;
      instr_valid_q <= 1'b0;
      if (pend_set)
        trig_pend_q <= 1'b1;
      if (scan_start) begin
        in_prev_q    <= in_cur_q;
        in_cur_q     <= in_pins;
        scan_count_q <= scan_count_q + CNT_W'(1);
      end
      case (state_q)
        S_HDR: begin
          if (byte_valid) begin
            if (byte_addr == ADDR_W'(0)) start_hi_q <= byte_data;
            if (byte_addr == ADDR_W'(1)) start_q    <= ADDR_W'({start_hi_q, byte_data});
            if (byte_addr == ADDR_W'(2)) end_hi_q   <= byte_data;
            if (byte_addr == ADDR_W'(3)) begin
              end_q <= end_d;
              if (hdr_bad) begin
                cfg_err_q <= 1'b1;
                state_q   <= S_HALT;
              end else begin
                state_q   <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (byte_valid && in_range) begin
            instr_valid_q <= 1'b1;
            instr_byte_q  <= byte_data;
            if (byte_addr == end_q) begin
              // The pending trigger is consumed by this scan end either way.
              trig_pend_q   <= 1'b0;
              restart_req_q <= run_go;
              state_q       <= run_go ? S_RESTART : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_go) begin
            restart_req_q <= 1'b1;
            state_q       <= S_RESTART;
          end
        end
        S_RESTART: begin
          if (restart_ack) begin
            restart_req_q <= 1'b0;
            state_q       <= S_RUN;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign restart_req  = restart_req_q;
  assign restart_addr = start_q;
  assign instr_valid  = instr_valid_q;
  assign instr_byte   = instr_byte_q;
  assign in_cur       = in_cur_q;
  assign in_prev      = in_prev_q;
  assign scan_pulse   = scan_pulse_q;
  assign scan_count   = scan_count_q;
  assign overrun      = overrun_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_scan_seq.sv
// Randomized bench for the scan sequencer with a scan-level reference model.
module tb_tt_um_jimktrains_vslc_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n, trig_in, tick, clr_flags, byte_valid, restart_ack;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [7:0]  byte_data, in_pins;
  logic [9:0]  byte_addr;
  logic        restart_req, instr_valid, scan_pulse, overrun, cfg_err;
  logic [9:0]  restart_addr;
  logic [7:0]  instr_byte, in_cur, in_prev;
  logic [15:0] scan_count;

  tt_um_jimktrains_vslc_scan_seq #(.ADDR_W(10), .IN_W(8), .CNT_W(16), .PER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .trig_in(trig_in), .tick(tick), .period(period),
    .clr_flags(clr_flags), .byte_valid(byte_valid), .byte_data(byte_data), .byte_addr(byte_addr),
    .restart_ack(restart_ack), .in_pins(in_pins), .restart_req(restart_req),
    .restart_addr(restart_addr), .instr_valid(instr_valid), .instr_byte(instr_byte),
    .in_cur(in_cur), .in_prev(in_prev), .scan_pulse(scan_pulse), .scan_count(scan_count),
    .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: what a scan-level observer expects.
  logic [15:0] m_count;
  logic [7:0]  m_cur, m_prev;
  logic        m_ovr, m_run;
  logic [9:0]  m_start, m_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc();
    chk("idle_iv", 32'(instr_valid), 32'd0);
  endtask

  task automatic model_reset();
    m_count = '0; m_cur = '0; m_prev = '0; m_ovr = 1'b0; m_run = 1'b0;
  endtask

  task automatic model_scan_start();
    m_prev = m_cur;
    m_cur  = in_pins;
    m_count++;
    m_run  = 1'b1;
  endtask

  task automatic check_scan_start(input string tag);
    chk({tag, "_pulse"}, 32'(scan_pulse), 32'd1);
    chk({tag, "_count"}, 32'(scan_count), 32'(m_count));
    chk({tag, "_cur"},   32'(in_cur),     32'(m_cur));
    chk({tag, "_prev"},  32'(in_prev),    32'(m_prev));
  endtask

  task automatic send_byte(input logic [9:0] a, input logic [7:0] d);
    logic exp_v;
    exp_v = m_run && (a >= m_start) && (a <= m_end);
    byte_valid = 1'b1; byte_addr = a; byte_data = d;
    cyc();
    byte_valid = 1'b0;
    chk("instr_valid", 32'(instr_valid), 32'(exp_v));
    if (exp_v) begin
      chk("instr_byte", 32'(instr_byte), 32'(d));
      if (a == m_end) m_run = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic load_header(input logic [15:0] s, input logic [15:0] e);
    logic [9:0] st, en;
    logic ok;
    st = s[9:0];
    en = e[9:0];
    ok = (en != 0) && (en >= st) && (st >= 10'd4);
    m_run = 1'b0;
    send_byte(10'd0, s[15:8]);
    send_byte(10'd1, s[7:0]);
    send_byte(10'd2, e[15:8]);
    if (ok) begin
      m_start = st;
      m_end   = en;
      model_scan_start();
      m_run = 1'b0;
    end
    send_byte(10'd3, e[7:0]);
    if (ok) begin
      m_run = 1'b1;
      check_scan_start("hdr");
    end else begin
      chk("cfg_err", 32'(cfg_err), 32'd1);
      chk("hdr_no_pulse", 32'(scan_pulse), 32'd0);
    end
  endtask

  // Program bytes start..end-1 with stray out-of-range bytes, then ticks.
  task automatic body(input int nticks);
    logic [15:0] pmax;
    for (int a = int'(m_start); a < int'(m_end); a++) begin
      send_byte(10'(a), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
      if (a == int'(m_start)) begin
        send_byte(m_start - 10'd1, 8'($urandom));
        send_byte(m_end + 10'd1, 8'($urandom));
      end
    end
    pmax = (period == 16'd0) ? 16'd1 : period;
    for (int t = 0; t < nticks; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    if ((mode == 2'd2) && (nticks >= int'(pmax))) m_ovr = 1'b1;
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic finish_scan();
    send_byte(m_end, 8'($urandom));
  endtask

  task automatic do_ack(input logic stray);
    chk("rr_set", 32'(restart_req), 32'd1);
    chk("rr_addr", 32'(restart_addr), 32'(m_start));
    repeat ($urandom_range(0, 2)) begin
      cyc();
      chk("rr_held", 32'(restart_req), 32'd1);
    end
    if (stray) send_byte(m_start, 8'($urandom));
    model_scan_start();
    restart_ack = 1'b1;
    cyc();
    restart_ack = 1'b0;
    check_scan_start("ack");
    chk("rr_clr", 32'(restart_req), 32'd0);
    cyc();
    chk("pulse_1cyc", 32'(scan_pulse), 32'd0);
  endtask

  task automatic check_no_rr(input int n);
    repeat (n) cyc();
    chk("rr_idle", 32'(restart_req), 32'd0);
  endtask

  task automatic wait_rr(input int budget);
    int k = 0;
    while (!restart_req && (k < budget)) begin
      cyc();
      k++;
    end
    chk("rr_wait", 32'(restart_req), 32'd1);
  endtask

  task automatic trig_wait_check();
    trig_in = 1'b1;
    cyc(); chk("trig_lat1", 32'(restart_req), 32'd0);
    cyc(); chk("trig_lat2", 32'(restart_req), 32'd0);
    cyc(); chk("trig_lat3", 32'(restart_req), 32'd1);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
    m_ovr = 1'b0;
    chk("clr_ovr", 32'(overrun), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mode = 2'd0; trig_in = 1'b0; tick = 1'b0; period = 16'd0;
    clr_flags = 1'b0; byte_valid = 1'b0; byte_data = 8'd0; byte_addr = 10'd0;
    restart_ack = 1'b0; in_pins = 8'd0;
    model_reset();
    m_start = '0; m_end = '0;
    repeat (3) cyc();
    chk("rst_rr",    32'(restart_req),  32'd0);
    chk("rst_iv",    32'(instr_valid),  32'd0);
    chk("rst_ib",    32'(instr_byte),   32'd0);
    chk("rst_pulse", 32'(scan_pulse),   32'd0);
    chk("rst_count", 32'(scan_count),   32'd0);
    chk("rst_ovr",   32'(overrun),      32'd0);
    chk("rst_cfg",   32'(cfg_err),      32'd0);
    chk("rst_cur",   32'(in_cur),       32'd0);
    chk("rst_prev",  32'(in_prev),      32'd0);
    chk("rst_addr",  32'(restart_addr), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Free-run with header 00 08 00 0B
    in_pins = 8'($urandom);
    load_header(16'h0008, 16'h000B);
    body(0); finish_scan(); do_ack(1'b1);
    body(0); finish_scan();
    in_pins = 8'h00;
    do_ack(1'b0);
    in_pins = 8'hA5;
    cyc();
    chk("in_cur_hold", 32'(in_cur), 32'h00);
    body(0); finish_scan(); do_ack(1'b0);
    chk("in_cur_new", 32'(in_cur), 32'hA5);
    chk("in_prev_old", 32'(in_prev), 32'h00);
    repeat (4) begin
      in_pins = 8'($urandom);
      body(0); finish_scan(); do_ack(1'($urandom_range(0, 1)));
    end

    // External trigger
    mode = 2'd1;
    body(0); finish_scan();
    check_no_rr(3);
    trig_wait_check();
    do_ack(1'b0);
    trig_in = 1'b0; repeat (3) cyc();
    trig_in = 1'b1; repeat (3) cyc();
    m_ovr = 1'b1;
    chk("ovr_trig", 32'(overrun), 32'd1);
    trig_in = 1'b0; repeat (3) cyc();
    trig_in = 1'b1; repeat (3) cyc();
    body(0); finish_scan();
    do_ack(1'b0);
    body(0); finish_scan();
    check_no_rr(4);
    pulse_clr();
    trig_in = 1'b0; repeat (4) cyc();
    trig_wait_check();
    do_ack(1'b0);
    trig_in = 1'b0;

    // Periodic, period 5
    mode = 2'd2; period = 16'd5;
    body(2); finish_scan();
    check_no_rr(3);
    repeat (2) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    check_no_rr(3);
    tick = 1'b1; cyc(); tick = 1'b0;
    wait_rr(4);
    chk("per_no_ovr", 32'(overrun), 32'd0);
    do_ack(1'b0);
    body(7); finish_scan();
    do_ack(1'b0);
    pulse_clr();
    period = 16'd0;
    body(0); finish_scan();
    check_no_rr(3);
    tick = 1'b1; cyc(); tick = 1'b0;
    wait_rr(4);
    chk("per0_no_ovr", 32'(overrun), 32'd0);
    do_ack(1'b0);

    // Async reset while a restart is outstanding
    mode = 2'd0;
    body(0); finish_scan();
    chk("pre_rst_rr", 32'(restart_req), 32'd1);
    chk("pre_rst_iv", 32'(instr_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rr",    32'(restart_req), 32'd0);
    chk("arst_iv",    32'(instr_valid), 32'd0);
    chk("arst_count", 32'(scan_count),  32'd0);
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    in_pins = 8'($urandom);
    load_header(16'hFC10, 16'h0413);
    body(0); finish_scan(); do_ack(1'b0);

    // Bad headers halt the sequencer
    begin
      logic [15:0] bad_s [3];
      logic [15:0] bad_e [3];
      bad_s[0] = 16'h0008; bad_e[0] = 16'h0000;
      bad_s[1] = 16'h0002; bad_e[1] = 16'h0008;
      bad_s[2] = 16'h0020; bad_e[2] = 16'h0010;
      for (int i = 0; i < 3; i++) begin
        do_reset();
        chk("cfg_clr", 32'(cfg_err), 32'd0);
        load_header(bad_s[i], bad_e[i]);
        send_byte(10'd8, 8'($urandom));
        send_byte(10'd11, 8'($urandom));
        check_no_rr(3);
        chk("halt_count", 32'(scan_count), 32'd0);
      end
    end

    // Smallest legal program: a single byte at address 4
    do_reset();
    load_header(16'h0004, 16'h0004);
    body(0); finish_scan(); do_ack(1'b0);
    chk("min_cfg", 32'(cfg_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
